// File: rtl/pc_redirect_ctrl.sv
// PC redirect controller: forms branch/JAL/JALR targets, checks alignment, hands off to fetch, holds flush.
// Optional PC_REDIR_STATS_EN adds saturating redirect and misalignment counters.
module pc_redirect_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            br_valid,
    output logic            br_ready,
    input  logic            br_taken,
    input  logic            br_is_jalr,
    input  logic [XLEN-1:0] br_pc,
    input  logic [XLEN-1:0] br_rs1,
    input  logic [XLEN-1:0] br_imm,
    output logic            redir_valid,
    input  logic            redir_ready,
    output logic [XLEN-1:0] redir_pc,
    output logic            flush,
    output logic            misalign_err,
    output logic [XLEN-1:0] err_pc,
    output logic [15:0]     stat_redir_cnt,
    output logic [15:0]     stat_err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_ISSUE,
        S_FLUSH
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic            jalr_q, jalr_d;
    logic [XLEN-1:0] redir_pc_q, redir_pc_d;
    logic [XLEN-1:0] err_pc_q, err_pc_d;
    logic            misalign_q, misalign_d;
    logic [3:0]      cnt_q, cnt_d;

    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] pcrel_sum;
    logic [XLEN-1:0] target;
    logic            redir_fire;

    // Operands are taken from the capture registers so the adder path starts at a flop.
    always_comb begin
        jalr_sum  = rs1_q + imm_q;
        pcrel_sum = pc_q + (imm_q << 1);
        target    = jalr_q ? {jalr_sum[XLEN-1:1], 1'b0} : pcrel_sum;
    end

    assign redir_fire = (state_q == S_ISSUE) && redir_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        rs1_d      = rs1_q;
        imm_d      = imm_q;
        jalr_d     = jalr_q;
        redir_pc_d = redir_pc_q;
        err_pc_d   = err_pc_q;
        misalign_d = 1'b0;
        cnt_d      = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (br_valid && br_taken) begin
                    pc_d    = br_pc;
                    rs1_d   = br_rs1;
                    imm_d   = br_imm;
                    jalr_d  = br_is_jalr;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (target[1]) begin
                    misalign_d = 1'b1;
                    err_pc_d   = target;
                    state_d    = S_IDLE;
                end else begin
                    redir_pc_d = target;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (redir_ready) begin
                    if (FLUSH_LOAD == 4'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = FLUSH_LOAD;
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            rs1_q      <= '0;
            imm_q      <= '0;
            jalr_q     <= 1'b0;
            redir_pc_q <= '0;
            err_pc_q   <= '0;
            misalign_q <= 1'b0;
            cnt_q      <= 4'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            rs1_q      <= rs1_d;
            imm_q      <= imm_d;
            jalr_q     <= jalr_d;
            redir_pc_q <= redir_pc_d;
            err_pc_q   <= err_pc_d;
            misalign_q <= misalign_d;
            cnt_q      <= cnt_d;
        end
    end

    assign br_ready     = (state_q == S_IDLE);
    assign redir_valid  = (state_q == S_ISSUE);
    assign flush        = (state_q == S_ISSUE) || (state_q == S_FLUSH);
    assign misalign_err = misalign_q;
    assign redir_pc     = redir_pc_q;
    assign err_pc       = err_pc_q;

`ifdef PC_REDIR_STATS_EN
    logic [15:0] stat_redir_q, stat_redir_d;
    logic [15:0] stat_err_q, stat_err_d;

    // Both counters stick at all-ones rather than wrapping.
    always_comb begin
        stat_redir_d = stat_redir_q;
        stat_err_d   = stat_err_q;
        if (redir_fire && (stat_redir_q != 16'hFFFF)) begin
            stat_redir_d = stat_redir_q + 16'd1;
        end
        if (misalign_d && (stat_err_q != 16'hFFFF)) begin
            stat_err_d = stat_err_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_redir_q <= 16'd0;
            stat_err_q   <= 16'd0;
        end else begin
            stat_redir_q <= stat_redir_d;
            stat_err_q   <= stat_err_d;
        end
    end

    assign stat_redir_cnt = stat_redir_q;
    assign stat_err_cnt   = stat_err_q;
`else
    logic unused_fire;
    assign unused_fire    = redir_fire;
    assign stat_redir_cnt = 16'd0;
    assign stat_err_cnt   = 16'd0;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed vector bench for pc_redirect_ctrl: target math, alignment errors,
// backpressure, not-taken, reset mid-issue and optional statistics.
module tb_pc_redirect_ctrl;

    localparam int FL = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        br_valid;
    logic        br_ready;
    logic        br_taken;
    logic        br_is_jalr;
    logic [31:0] br_pc;
    logic [31:0] br_rs1;
    logic [31:0] br_imm;
    logic        redir_valid;
    logic        redir_ready;
    logic [31:0] redir_pc;
    logic        flush;
    logic        misalign_err;
    logic [31:0] err_pc;
    logic [15:0] stat_redir_cnt;
    logic [15:0] stat_err_cnt;

    pc_redirect_ctrl #(
        .XLEN(32),
        .FLUSH_CYCLES(FL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .br_valid(br_valid),
        .br_ready(br_ready),
        .br_taken(br_taken),
        .br_is_jalr(br_is_jalr),
        .br_pc(br_pc),
        .br_rs1(br_rs1),
        .br_imm(br_imm),
        .redir_valid(redir_valid),
        .redir_ready(redir_ready),
        .redir_pc(redir_pc),
        .flush(flush),
        .misalign_err(misalign_err),
        .err_pc(err_pc),
        .stat_redir_cnt(stat_redir_cnt),
        .stat_err_cnt(stat_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        jalr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] imm;
        logic [31:0] target;
        logic        err;
    } vec_t;

    vec_t vecs[7];

    int checks = 0;
    int errors = 0;
    int n_redir = 0;
    int n_err = 0;
    logic [31:0] last_redir = 32'h0;
    logic [31:0] last_err = 32'h0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!br_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", {31'd0, br_ready}, 32'd1);
    endtask

    // Present one taken transfer and follow it to completion with redir_ready=1.
    task automatic run_vec(input vec_t v);
        int n;
        wait_idle();
        br_valid   = 1'b1;
        br_taken   = 1'b1;
        br_is_jalr = v.jalr;
        br_pc      = v.pc;
        br_rs1     = v.rs1;
        br_imm     = v.imm;
        @(negedge clk);
        br_valid = 1'b0;
        chk("calc_ready", {31'd0, br_ready}, 32'd0);
        chk("calc_valid", {31'd0, redir_valid}, 32'd0);
        @(negedge clk);
        if (v.err) begin
            n_err++;
            last_err = v.target;
            chk("err_pulse", {31'd0, misalign_err}, 32'd1);
            chk("err_pc", err_pc, v.target);
            chk("err_valid", {31'd0, redir_valid}, 32'd0);
            chk("err_flush", {31'd0, flush}, 32'd0);
            chk("err_ready", {31'd0, br_ready}, 32'd1);
            chk("err_redir_pc", redir_pc, last_redir);
            @(negedge clk);
            chk("err_pulse_end", {31'd0, misalign_err}, 32'd0);
        end else begin
            n_redir++;
            last_redir = v.target;
            chk("redir_valid", {31'd0, redir_valid}, 32'd1);
            chk("redir_pc", redir_pc, v.target);
            chk("redir_noerr", {31'd0, misalign_err}, 32'd0);
            n = 0;
            while (flush && n < 20) begin
                n++;
                @(negedge clk);
                if (flush) begin
                    chk("flush_valid_drop", {31'd0, redir_valid}, 32'd0);
                end
            end
            chk("flush_len", n, FL + 1);
            chk("post_ready", {31'd0, br_ready}, 32'd1);
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'h0000_1000, 32'hDEAD_0000, 32'h0000_0008,
                    32'h0000_1010, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_0004, 32'h0000_0000, 32'hFFFF_FFFC,
                    32'hFFFF_FFFC, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_5000, 32'h0000_2001, 32'h0000_0004,
                    32'h0000_2004, 1'b0};
        vecs[3] = '{1'b1, 32'h0000_5000, 32'h0000_2000, 32'h0000_0002,
                    32'h0000_2002, 1'b1};
        vecs[4] = '{1'b0, 32'h0000_0100, 32'h0000_0040, 32'h0000_0001,
                    32'h0000_0102, 1'b1};
        vecs[5] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001,
                    32'h0000_0000, 1'b0};
        vecs[6] = '{1'b1, 32'h0000_0800, 32'h0000_3000, 32'hFFFF_FFFF,
                    32'h0000_2FFE, 1'b1};

        rst         = 1'b1;
        br_valid    = 1'b0;
        br_taken    = 1'b0;
        br_is_jalr  = 1'b0;
        br_pc       = '0;
        br_rs1      = '0;
        br_imm      = '0;
        redir_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, br_ready}, 32'd1);
        chk("rst_valid", {31'd0, redir_valid}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_merr", {31'd0, misalign_err}, 32'd0);
        chk("rst_redir_pc", redir_pc, 32'd0);
        chk("rst_err_pc", err_pc, 32'd0);
        chk("rst_stat_r", {16'd0, stat_redir_cnt}, 32'd0);
        chk("rst_stat_e", {16'd0, stat_err_cnt}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
        end

        // Not-taken request is consumed with no visible effect.
        wait_idle();
        br_valid = 1'b1;
        br_taken = 1'b0;
        br_is_jalr = 1'b0;
        br_pc = 32'h0000_7000;
        br_imm = 32'h0000_0010;
        @(negedge clk);
        br_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("nt_ready", {31'd0, br_ready}, 32'd1);
            chk("nt_valid", {31'd0, redir_valid}, 32'd0);
            chk("nt_flush", {31'd0, flush}, 32'd0);
            chk("nt_merr", {31'd0, misalign_err}, 32'd0);
            chk("nt_redir_pc", redir_pc, last_redir);
            chk("nt_err_pc", err_pc, last_err);
            @(negedge clk);
        end

        // Backpressure: fetch stalls 5 cycles, a competing request is ignored.
        redir_ready = 1'b0;
        br_valid = 1'b1;
        br_taken = 1'b1;
        br_is_jalr = 1'b0;
        br_pc = 32'h0000_4000;
        br_imm = 32'h0000_0010;
        @(negedge clk);
        br_pc = 32'h0000_9000;
        br_imm = 32'h0000_0100;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", {31'd0, redir_valid}, 32'd1);
            chk("bp_pc", redir_pc, 32'h0000_4020);
            chk("bp_flush", {31'd0, flush}, 32'd1);
            chk("bp_ready", {31'd0, br_ready}, 32'd0);
            @(negedge clk);
        end
        br_valid = 1'b0;
        redir_ready = 1'b1;
        @(negedge clk);
        n_redir++;
        last_redir = 32'h0000_4020;
        chk("bp_drop_valid", {31'd0, redir_valid}, 32'd0);
        chk("bp_flush_hold", {31'd0, flush}, 32'd1);
        repeat (FL) @(negedge clk);
        chk("bp_done_ready", {31'd0, br_ready}, 32'd1);
        chk("bp_done_flush", {31'd0, flush}, 32'd0);
        @(negedge clk);
        chk("bp_no_accept", {31'd0, br_ready}, 32'd1);
        chk("bp_pc_kept", redir_pc, 32'h0000_4020);

`ifdef PC_REDIR_STATS_EN
        chk("stat_redir", {16'd0, stat_redir_cnt}, n_redir);
        chk("stat_err", {16'd0, stat_err_cnt}, n_err);
`else
        chk("stat_redir_off", {16'd0, stat_redir_cnt}, 32'd0);
        chk("stat_err_off", {16'd0, stat_err_cnt}, 32'd0);
`endif

        // Reset while a redirect waits in ISSUE.
        redir_ready = 1'b0;
        br_valid = 1'b1;
        br_taken = 1'b1;
        br_is_jalr = 1'b0;
        br_pc = 32'h0000_6000;
        br_imm = 32'h0000_0020;
        @(negedge clk);
        br_valid = 1'b0;
        @(negedge clk);
        chk("mid_valid", {31'd0, redir_valid}, 32'd1);
        chk("mid_pc", redir_pc, 32'h0000_6040);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_valid", {31'd0, redir_valid}, 32'd0);
        chk("mrst_flush", {31'd0, flush}, 32'd0);
        chk("mrst_ready", {31'd0, br_ready}, 32'd1);
        chk("mrst_pc", redir_pc, 32'd0);
        chk("mrst_err_pc", err_pc, 32'd0);
        chk("mrst_stat_r", {16'd0, stat_redir_cnt}, 32'd0);
        chk("mrst_stat_e", {16'd0, stat_err_cnt}, 32'd0);
        redir_ready = 1'b1;
        @(negedge clk);
        chk("mrst_stay_idle", {31'd0, redir_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_redirect_ctrl.md
# pc_redirect_ctrl

Sequences control-transfer redirects for the core's fetch unit. It accepts a resolved branch/jump from the execute stage and forms the target: PC plus the immediate shifted left by one for branches and JAL, or rs1 plus the immediate with bit 0 cleared for JALR. It then checks word alignment, hands the target to fetch over a valid/ready handshake, and holds a pipeline flush for a programmable number of cycles. It sits between the execute stage and the PC/fetch logic, and is the only block that drives a PC redirect.

## Interface
- XLEN, 32, datapath/address width
- FLUSH_CYCLES, 2, cycles `flush` stays high after redirect handshake (legal 0..15)

- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- br_valid  input  1  execute stage presents a resolved control transfer
- br_ready  output  1  controller can accept (high only in IDLE)
- br_taken  input  1  transfer is taken (JAL/JALR always drive 1)
- br_is_jalr  input  1  1 = JALR target rule, 0 = PC-relative rule
- br_pc  input  XLEN  PC of the branch/jump instruction
- br_rs1  input  XLEN  rs1 value (JALR only)
- br_imm  input  XLEN  sign-extended immediate; halfword units for branch/JAL, byte units for JALR
- redir_valid  output  1  redirect target valid
- redir_ready  input  1  fetch accepts redirect
- redir_pc  output  XLEN  redirect target
- flush  output  1  kill younger in-flight instructions
- misalign_err  output  1  one-cycle pulse: computed target not word aligned
- err_pc  output  XLEN  offending target, valid with misalign_err, held until next error
- stat_redir_cnt  output  16  completed redirects (see Configuration)
- stat_err_cnt  output  16  misalignment errors (see Configuration)

## Operation
- States: IDLE, CALC, ISSUE, FLUSH.
- IDLE: `br_ready` = 1. On `br_valid` & `br_taken`, register pc, rs1, imm and is_jalr, then go to CALC. On `br_valid` & !`br_taken`, consume the request and stay in IDLE with no other effect.
- CALC: target = is_jalr ? ((rs1 + imm) & ~1) : (pc + (imm << 1)). All sums are modulo 2^XLEN; wrap-around is not an error.
  - If target[1] = 1: pulse `misalign_err`, load `err_pc` = target, return to IDLE. No redirect and no flush.
  - Otherwise: load `redir_pc` = target and go to ISSUE.
- ISSUE: `redir_valid` = 1 and `flush` = 1. `redir_pc` is stable while waiting. On `redir_ready`, go to FLUSH and load the counter with FLUSH_CYCLES. If FLUSH_CYCLES = 0, go straight to IDLE.
- FLUSH: `flush` = 1. The counter decrements each cycle. When it reaches 1, go to IDLE on the next edge. `flush` is high for exactly FLUSH_CYCLES cycles after the handshake cycle.
- `br_valid` is ignored outside IDLE. Upstream must hold its request until accepted.
- `rst` in any state: next state is IDLE and all outputs take reset values. An in-progress redirect is dropped.

## Timing
- Reset values:
  - `br_ready` = 1
  - `redir_valid`, `flush`, `misalign_err` = 0
  - `redir_pc`, `err_pc` = 0
  - stat counters = 0
- Accept edge is E0. CALC occupies E0–E1. `redir_valid` rises after E1. The minimum redirect latency is 2 cycles from accept.
- Error path: `misalign_err` is high for the single cycle after E1. `br_ready` returns high in that same cycle.
- Handshake completes on the edge where `redir_valid` & `redir_ready`. `redir_valid` drops after that edge.
- Back-to-back taken transfers: minimum spacing is 3 + FLUSH_CYCLES cycles.
- All outputs are registered or decoded from state only. There is no combinational path from an input to an output.

## Configuration
- `PC_REDIR_STATS_EN` defined:
  - `stat_redir_cnt` increments on each redirect handshake.
  - `stat_err_cnt` increments on each `misalign_err`.
  - Both saturate at 16'hFFFF and clear on `rst`.
- Not defined: both stat outputs are tied to 0 and no counter flops exist. All other behaviour is identical.

## Test plan
- Branch forward, FLUSH_CYCLES = 2:
  - Stimulus: pc = 0x0000_1000, imm = 0x0000_0008, taken, `redir_ready` = 1.
  - Required: `redir_pc` = 0x0000_1010 and `redir_valid` high 2 cycles after accept, then `flush` high for 3 cycles total, then `br_ready` = 1.
- Backward wrap:
  - Stimulus: pc = 0x0000_0004, imm = 0xFFFF_FFFC.
  - Required: `redir_pc` = 0xFFFF_FFFC, no error.
- JALR bit-0 clear and misalignment:
  - rs1 = 0x2001, imm = 0x4: target 0x2004, redirect issued.
  - rs1 = 0x2000, imm = 0x2: target 0x2002, `misalign_err` pulse, `err_pc` = 0x2002, no `redir_valid`, no `flush`.
- Not-taken and backpressure:
  - Not-taken request: consumed, state stays IDLE, no outputs change.
  - Taken request with `redir_ready` held 0 for 5 cycles: `redir_valid` and `redir_pc` are stable and `flush` is high throughout. A new `br_valid` during this time is not accepted.
- Reset mid-ISSUE:
  - Stimulus: assert `rst` while `redir_valid` = 1.
  - Required: next cycle `redir_valid` = 0, `flush` = 0, `br_ready` = 1, `redir_pc` = 0.
- With `PC_REDIR_STATS_EN`:
  - Stimulus: 3 redirects and 1 misalignment.
  - Required: `stat_redir_cnt` = 3, `stat_err_cnt` = 1.
  - Without the macro, both read 0.
